// File: rtl/key_bounce_gen.sv
// key_bounce_gen
// Emulates a mechanical key on an active-low pin. A one-cycle `press` in IDLE
// starts a sequence: a pseudo-random press bounce window, a stable pressed
// interval, and a pseudo-random release bounce window. A `done` pulse follows.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   press    in   start request, only looked at in IDLE
//   key_pin  out  emulated key, active-low, idle level 1 (registered)
//   busy     out  high while a sequence is in progress (registered)
//   done     out  one-cycle pulse in the first IDLE cycle after a sequence
//
// Handshake: `press` is a one-cycle request that is taken only while the FSM
// is in IDLE (busy=0, including the cycle where done=1); outside IDLE it is
// dropped, never queued.
module key_bounce_gen #(
  parameter int          BOUNCE_CYCLES = 250_000,
  parameter int          HOLD_CYCLES   = 1_000_000,
  parameter int          SEG_BITS      = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press,
  output logic key_pin,
  output logic busy,
  output logic done
);

  localparam int MAX_CYC = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    P_BOUNCE = 2'd1,
    HOLD     = 2'd2,
    R_BOUNCE = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  win_cnt, win_cnt_nx;
  logic [SEG_BITS:0] seg_cnt, seg_cnt_nx;
  logic [15:0]       lfsr, lfsr_nx;
  logic              key_pin_nx, busy_nx, done_nx;

  logic [15:0]       lfsr_step;
  logic [SEG_BITS:0] seg_len;
  logic              last_bounce, last_hold, seg_exp;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  assign lfsr_step   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // One extra bit so 2^SEG_BITS is representable.
  assign seg_len     = {1'b0, lfsr[SEG_BITS-1:0]} + {{SEG_BITS{1'b0}}, 1'b1};
  // The window counter starts at 0 on state entry, so the final cycle of a
  // window of N cycles is the one where it reads N-1.
  assign last_bounce = (win_cnt == CNT_W'(BOUNCE_CYCLES - 1));
  assign last_hold   = (win_cnt == CNT_W'(HOLD_CYCLES - 1));
  // The segment counter is loaded with L; reading 1 means this is the last
  // cycle of the segment, so the toggle lands L cycles after the start.
  assign seg_exp     = (seg_cnt == {{SEG_BITS{1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      seg_cnt <= '0;
      lfsr    <= LFSR_SEED;
      key_pin <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      win_cnt <= win_cnt_nx;
      seg_cnt <= seg_cnt_nx;
      lfsr    <= lfsr_nx;
      key_pin <= key_pin_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    win_cnt_nx = win_cnt + CNT_W'(1);
    seg_cnt_nx = seg_cnt;
    lfsr_nx    = lfsr;
    key_pin_nx = key_pin;
    busy_nx    = busy;
    done_nx    = 1'b0;

    case (state)
      IDLE: begin
        win_cnt_nx = '0;
        key_pin_nx = 1'b1;
        busy_nx    = 1'b0;
        if (press) begin
          state_nx   = P_BOUNCE;
          key_pin_nx = 1'b0;
          busy_nx    = 1'b1;
          seg_cnt_nx = seg_len;
          lfsr_nx    = lfsr_step;
        end
      end

      P_BOUNCE: begin
        seg_cnt_nx = seg_cnt - {{SEG_BITS{1'b0}}, 1'b1};
        // Window end takes priority: the last segment is simply truncated.
        if (last_bounce) begin
          state_nx   = HOLD;
          win_cnt_nx = '0;
          seg_cnt_nx = '0;
          key_pin_nx = 1'b0;
        end else if (seg_exp) begin
          key_pin_nx = ~key_pin;
          seg_cnt_nx = seg_len;
          lfsr_nx    = lfsr_step;
        end
      end

      HOLD: begin
        key_pin_nx = 1'b0;
        if (last_hold) begin
          state_nx   = R_BOUNCE;
          win_cnt_nx = '0;
          key_pin_nx = 1'b1;
          seg_cnt_nx = seg_len;
          lfsr_nx    = lfsr_step;
        end
      end

      R_BOUNCE: begin
        seg_cnt_nx = seg_cnt - {{SEG_BITS{1'b0}}, 1'b1};
        if (last_bounce) begin
          state_nx   = IDLE;
          win_cnt_nx = '0;
          seg_cnt_nx = '0;
          key_pin_nx = 1'b1;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
        end else if (seg_exp) begin
          key_pin_nx = ~key_pin;
          seg_cnt_nx = seg_len;
          lfsr_nx    = lfsr_step;
        end
      end

      default: begin
        state_nx   = IDLE;
        win_cnt_nx = '0;
        key_pin_nx = 1'b1;
        busy_nx    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen with BOUNCE_CYCLES=20, HOLD_CYCLES=50, SEG_BITS=3.
// A behavioural model builds the whole expected pin waveform of a sequence as
// an array when a press is accepted; one process compares every cycle.
module tb_key_bounce_gen;

  localparam int          B    = 20;
  localparam int          H    = 50;
  localparam int          S    = 3;
  localparam int          SEQ  = 2 * B + H;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic press = 1'b0;
  logic key_pin, busy, done;

  always #5 clk = ~clk;

  key_bounce_gen #(
    .BOUNCE_CYCLES(B),
    .HOLD_CYCLES  (H),
    .SEG_BITS     (S),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .press  (press),
    .key_pin(key_pin),
    .busy   (busy),
    .done   (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr   = SEED;
  bit          m_active = 1'b0;
  int          m_cyc    = 0;
  logic        m_key    = 1'b1;
  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;
  logic        pat [0:SEQ-1];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Lay out one bounce window: segments of random length alternate the pin,
  // the last one is cut off at the window edge.
  function automatic void fill_bounce(input int start, input logic init);
    logic pin;
    int   t;
    int   len;
    pin = init;
    t   = 0;
    while (t < B) begin
      len    = int'(m_lfsr & ((16'd1 << S) - 16'd1)) + 1;
      m_lfsr = lfsr_next(m_lfsr);
      for (int k = t; k < t + len && k < B; k++) pat[start + k] = pin;
      t   = t + len;
      pin = ~pin;
    end
  endfunction

  function automatic void build_pattern();
    fill_bounce(0, 1'b0);
    for (int k = B; k < B + H; k++) pat[k] = 1'b0;
    fill_bounce(B + H, 1'b1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_lfsr   = SEED;
        m_key    = 1'b1;
        m_busy   = 1'b0;
        m_done   = 1'b0;
      end else if (!m_active && press) begin
        build_pattern();
        m_active = 1'b1;
        m_cyc    = 0;
        m_key    = pat[0];
        m_busy   = 1'b1;
        m_done   = 1'b0;
      end else if (m_active) begin
        m_cyc++;
        if (m_cyc == SEQ) begin
          m_active = 1'b0;
          m_key    = 1'b1;
          m_busy   = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_key  = pat[m_cyc];
          m_done = 1'b0;
        end
      end else begin
        m_key  = 1'b1;
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("key_pin", 32'(key_pin), 32'(m_key));
      check("busy",    32'(busy),    32'(m_busy));
      check("done",    32'(done),    32'(m_done));
      if (m_done) check("lfsr_at_done", 32'(dut.lfsr), 32'(m_lfsr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_press();
    @(posedge clk); #1 press = 1'b1;
    @(posedge clk); #1 press = 1'b0;
  endtask

  // Press from reset-fresh LFSR; checks hand-derived values for seed 16'hACE1:
  // segments 2,4,8,(8 truncated) -> pin 0@0, 1@2, 0@6, 1@14, forced 0@20.
  task automatic run_directed(input bit with_ignores);
    int busy_n;
    int done_n;
    busy_n = 0;
    done_n = 0;
    pulse_press();
    for (int k = 0; k <= SEQ; k++) begin
      @(negedge clk);
      if (k == 0)  begin check("c0_key", 32'(key_pin), 0); check("c0_busy", 32'(busy), 1); end
      if (k == 1)  check("c1_key", 32'(key_pin), 0);
      if (k == 2)  check("c2_key", 32'(key_pin), 1);
      if (k == 6)  check("c6_key", 32'(key_pin), 0);
      if (k == 14) check("c14_key", 32'(key_pin), 1);
      if (k == 19) check("c19_key", 32'(key_pin), 1);
      if (k == 20) check("c20_key", 32'(key_pin), 0);
      if (k == 69) check("c69_key", 32'(key_pin), 0);
      if (k == 70) check("c70_key", 32'(key_pin), 1);
      if (k == SEQ) begin
        check("c90_key",  32'(key_pin), 1);
        check("c90_busy", 32'(busy), 0);
        check("c90_done", 32'(done), 1);
      end
      if (k < SEQ) busy_n += int'(busy);
      done_n += int'(done);
      @(posedge clk);
      #1 press = with_ignores && (k + 1 == 5 || k + 1 == 40 || k + 1 == 85 || k + 1 == SEQ);
    end
    check("busy_len", 32'(busy_n), 32'(SEQ));
    check("done_cnt", 32'(done_n), 1);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b0;
    press = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 press = 1'($urandom_range(0, 1));
    end
    #1;
    check("rst_key",  32'(key_pin), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1; press = 1'b0;
    repeat (5) @(posedge clk);

    // first press with ignored pulses and a back-to-back press at cycle 90
    run_directed(1'b1);
    @(negedge clk);
    check("b2b_key",  32'(key_pin), 0);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_done", 32'(done), 0);
    repeat (SEQ + 3) @(posedge clk);

    // third consecutive press, no reseed in between
    repeat ($urandom_range(1, 6)) @(posedge clk);
    pulse_press();
    repeat (SEQ + 3) @(posedge clk);

    // reset in the middle of HOLD
    pulse_press();
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_key",  32'(key_pin), 1);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_directed(1'b0);

    // random press traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1 press = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1 press = 1'b0;
    repeat (SEQ + 5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable mechanical-key emulator: on a one-cycle request it drives an active-low key pin with pseudo-random contact bounce, a stable pressed interval and a bounced release. It is the transmit end of the key-pin interface that `key_filter` receives. It is used for on-board self-test of the debounce path and as a drop-in stimulus source in benches, replacing behavioural key models. Default timing assumes the 50 MHz (20 ns) system clock.

## Interface
- `BOUNCE_CYCLES`, default 250_000: length of each bounce window (5 ms); must be ≥ 1.
- `HOLD_CYCLES`, default 1_000_000: stable-pressed interval (20 ms); must be ≥ 1.
- `SEG_BITS`, default 10: LFSR bits used for segment length; segment length is 1..2^SEG_BITS cycles; 1 ≤ SEG_BITS ≤ 16.
- `LFSR_SEED`, default 16'hACE1: 16-bit LFSR reload value; must be nonzero.

- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `press` input 1: start request, sampled only in IDLE.
- `key_pin` output 1: emulated key, active-low; idle level 1.
- `busy` output 1: high while a press sequence is in progress.
- `done` output 1: one-cycle pulse when a sequence completes.

## Operation
- Registered FSM states:
  - IDLE → P_BOUNCE on `press`=1.
  - P_BOUNCE → HOLD when the window counter reaches BOUNCE_CYCLES.
  - HOLD → R_BOUNCE after HOLD_CYCLES.
  - R_BOUNCE → IDLE after BOUNCE_CYCLES.
- Window counter:
  - width $clog2(max(BOUNCE_CYCLES, HOLD_CYCLES)+1).
  - cleared on every state entry; counts cycles spent in the current state.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts toward the MSB.
  - advances exactly once per segment reload and is otherwise frozen.
  - reloads LFSR_SEED only on reset, not at the start of each press.
- Segment:
  - length = lfsr[SEG_BITS-1:0] + 1, computed in SEG_BITS+1 bits with no overflow.
  - the segment counter reloads on bounce-state entry and on each expiry.
- P_BOUNCE:
  - entry drives `key_pin`=0.
  - each segment expiry toggles `key_pin` and advances the LFSR.
- R_BOUNCE:
  - entry drives `key_pin`=1.
  - toggles on segment expiry, same rule as P_BOUNCE.
- Window end:
  - the last segment is truncated.
  - `key_pin` is forced to 0 on entry to HOLD and to 1 on entry to IDLE, whatever the toggle parity.
- HOLD: `key_pin` = 0, constant.
- `press` outside IDLE is ignored and is never queued.
- `press` in the same cycle `done` is high is accepted, because the FSM is already in IDLE.

## Timing
- Reset values, applied asynchronously, immediately on `rst_n`=0:
  - state IDLE; `key_pin`=1, `busy`=0, `done`=0.
  - LFSR=LFSR_SEED; all counters 0.
- Reset mid-sequence aborts to IDLE with `key_pin`=1 and no `done` pulse.
- Cycle numbering: let cycle 0 be the first cycle after the edge that captures `press`=1 in IDLE. B = BOUNCE_CYCLES, H = HOLD_CYCLES.
  - Cycle 0: `key_pin`=0, `busy`=1.
  - Cycles 0..B-1: press bounce.
  - Cycles B..B+H-1: `key_pin`=0, stable.
  - Cycles B+H..2B+H-1: release bounce, starting at 1.
  - Cycle 2B+H: IDLE, `key_pin`=1, `busy`=0, `done`=1 for this cycle only.
- Segment timing: a segment of length L starting at cycle c toggles `key_pin` at cycle c+L, if c+L is still inside the window.
- All outputs are registered; there are no combinational paths from `press` to the outputs.

## Test plan
Benches run with BOUNCE_CYCLES=20, HOLD_CYCLES=50, SEG_BITS=3 unless noted.

- Reset: hold `rst_n`=0 for 10 cycles → `key_pin`=1, `busy`=0, `done`=0 throughout; `press` is ignored.
- Single press:
  - 1-cycle `press` → `key_pin` 0 at cycle 0.
  - `key_pin` constant 0 over cycles 20..69; `key_pin` 1 from cycle 90.
  - `busy` high for exactly 90 cycles; `done`=1 only at cycle 90.
- Bounce pattern: compare every `key_pin` toggle cycle and the LFSR value against a bench model seeded 16'hACE1 → exact match across three consecutive presses. This also confirms the LFSR is not re-seeded between presses.
- Ignore and back-to-back:
  - `press` pulses at cycles 5, 40 and 85 → no effect on any output.
  - `press` at cycle 90 → new sequence with cycle 0 at cycle 91.
- Reset mid-HOLD: `rst_n`=0 at cycle 30 → `key_pin`=1 and `busy`=0 without waiting for a clock edge; no `done`; the next press reproduces the first-press toggle pattern.
- Integration, with default parameters: `key_filter` driven by `key_pin`, one press → exactly one press event and one release event from `key_filter`; its key status is low only within the HOLD span plus its own filter delay.
